regfile_loader: RTL and testbench

REGFILE_LOADER -- requirements
Module: regfile_loader

---
 rtl/regfile_loader.sv | 152 +++++++++++++++
 tb/tb_regfile_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_loader.sv
// Moves a contiguous range of register-file entries out to a stream (dump) or
// writes them from a stream (load), with a running XOR checksum of the words moved.
module regfile_loader (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_load,
  input  logic [4:0]  cmd_first,
  input  logic [4:0]  cmd_last,
  output logic [4:0]  rf_read_reg,
  input  logic [31:0] rf_read_data,
  output logic        rf_reg_write,
  output logic [4:0]  rf_write_reg,
  output logic [31:0] rf_write_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_addr,
  output logic        out_last,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] checksum
);

  typedef enum logic [1:0] {StIdle, StDump, StLoad} state_e;

  state_e      state_q, state_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  last_q, last_d;
  logic        rem_q, rem_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic [4:0]  out_addr_q, out_addr_d;
  logic        out_last_q, out_last_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] checksum_q, checksum_d;

  logic cmd_hs, in_hs, out_hs, capture, at_last;

  assign cmd_hs  = cmd_valid && (state_q == StIdle);
  assign in_hs   = in_valid && (state_q == StLoad);
  assign out_hs  = out_valid_q && out_ready;
  assign at_last = (ptr_q == last_q);
  // The output register can refill in the same cycle it is being drained.
  assign capture = (state_q == StDump) && rem_q && (!out_valid_q || out_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      last_q      <= '0;
      rem_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      checksum_q  <= checksum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (cmd_hs && (cmd_first <= cmd_last)) state_d = cmd_load ? StLoad : StDump;
      StDump: if (out_hs && out_last_q) state_d = StIdle;
      StLoad: if (in_hs && at_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ptr_d       = ptr_q;
    last_d      = last_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    checksum_d  = checksum_q;

    if (cmd_hs) begin
      checksum_d = '0;
      ptr_d      = cmd_first;
      last_d     = cmd_last;
      rem_d      = 1'b1;
      if (cmd_first > cmd_last) begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
    end

    if (out_hs) begin
      checksum_d = checksum_q ^ out_data_q;
      if (out_last_q) done_d = 1'b1;
      if (!capture) out_valid_d = 1'b0;
    end

    // The pointer stops on the last index so a range ending at 31 never wraps.
    if (capture) begin
      out_valid_d = 1'b1;
      out_data_d  = rf_read_data;
      out_addr_d  = ptr_q;
      out_last_d  = at_last;
      if (at_last) rem_d = 1'b0;
      else         ptr_d = ptr_q + 5'd1;
    end

    if (in_hs) begin
      checksum_d = checksum_q ^ in_data;
      if (at_last) done_d = 1'b1;
      else         ptr_d  = ptr_q + 5'd1;
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign in_ready      = (state_q == StLoad);
  assign rf_read_reg   = ptr_q;
  assign rf_reg_write  = in_hs && (ptr_q != 5'd0) && !reset;
  assign rf_write_reg  = in_hs ? ptr_q : 5'd0;
  assign rf_write_data = in_hs ? in_data : 32'd0;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_addr      = out_addr_q;
  assign out_last      = out_last_q;
  assign done          = done_q;
  assign err           = err_q;
  assign checksum      = checksum_q;

endmodule

// File: tb/tb_regfile_loader.sv
// Directed plus randomized bench for regfile_loader; a behavioural register-file
// model predicts dumped words, register contents and checksums.
module tb_regfile_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_load;
  logic [4:0]  cmd_first, cmd_last;
  logic [4:0]  rf_read_reg;
  logic [31:0] rf_read_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic        out_valid, out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_addr;
  logic        out_last;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        busy, done, err;
  logic [31:0] checksum;

  int total = 0;
  int bad   = 0;

  logic [31:0] rf_mem   [32];
  logic [31:0] model_rf [32];
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;
  logic [31:0] load_words[$];

  always #5 clk = ~clk;

  // Register file seen by the DUT; preload port lets the bench seed contents.
  always @(posedge clk) begin
    if (pre_we) rf_mem[pre_idx] <= pre_val;
    else if (rf_reg_write) rf_mem[rf_write_reg] <= rf_write_data;
  end
  assign rf_read_data = rf_mem[rf_read_reg];

  regfile_loader dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
    .cmd_first(cmd_first), .cmd_last(cmd_last),
    .rf_read_reg(rf_read_reg), .rf_read_data(rf_read_data),
    .rf_reg_write(rf_reg_write), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .err(err), .checksum(checksum)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = 5'(idx); pre_val = val;
    model_rf[idx] = val;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic send_cmd(input bit load, input int first, input int last);
    check("cmd_ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_load = load; cmd_first = 5'(first); cmd_last = 5'(last);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_first = 5'($urandom); cmd_last = 5'($urandom);
  endtask

  task automatic check_rf();
    int mism = 0;
    for (int i = 0; i < 32; i++) if (rf_mem[i] !== model_rf[i]) mism++;
    check("rf_contents_mismatches", 32'(mism), 32'd0);
  endtask

  // policy: 0 = always ready, 1 = random ready, 2 = stall three cycles then ready
  task automatic do_dump(input int first, input int last, input int policy);
    int n = last - first + 1;
    int idx = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit rdy;
    logic [31:0] exp_ck = '0;
    logic [31:0] hd;
    logic [4:0]  ha;
    logic        hl;
    send_cmd(1'b0, first, last);
    check("dump_busy", 32'(busy), 32'd1);
    check("dump_no_early_valid", 32'(out_valid), 32'd0);
    while (idx < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("dump_first_valid", 32'(out_valid), 32'd1);
      if (stalled) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", out_data, hd);
        check("stall_addr", 32'(out_addr), 32'(ha));
        check("stall_last", 32'(out_last), 32'(hl));
      end
      check("dump_no_done", 32'(done), 32'd0);
      case (policy)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc > 3);
      endcase
      out_ready = rdy;
      if (policy == 0) check("dump_throughput", 32'(out_valid), 32'd1);
      if (out_valid && rdy) begin
        check("dump_data", out_data, model_rf[first + idx]);
        check("dump_addr", 32'(out_addr), 32'(first + idx));
        check("dump_last", 32'(out_last), 32'(idx == n - 1));
        exp_ck ^= model_rf[first + idx];
        idx++;
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1; hd = out_data; ha = out_addr; hl = out_last;
      end else begin
        stalled = 1'b0;
      end
    end
    if (idx < n) begin
      total++; bad++;
      $error("FAIL dump_timeout observed=%0d words expected=%0d", idx, n);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check("dump_done", 32'(done), 32'd1);
    check("dump_err", 32'(err), 32'd0);
    check("dump_idle", 32'(busy), 32'd0);
    check("dump_valid_drop", 32'(out_valid), 32'd0);
    check("dump_checksum", checksum, exp_ck);
    @(negedge clk);
    check("dump_done_pulse", 32'(done), 32'd0);
    check("dump_checksum_hold", checksum, exp_ck);
  endtask

  task automatic fill_random(input int n);
    load_words.delete();
    for (int i = 0; i < n; i++) load_words.push_back($urandom);
  endtask

  task automatic do_load(input int first, input int last, input bit gapped);
    int n = last - first + 1;
    int idx = 0;
    int cyc = 0;
    bit v;
    logic [31:0] exp_ck = '0;
    send_cmd(1'b1, first, last);
    check("load_busy", 32'(busy), 32'd1);
    while (idx < n && cyc < 300) begin
      cyc++;
      v = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? load_words[idx] : $urandom;
      #1;
      check("load_in_ready", 32'(in_ready), 32'd1);
      check("load_we", 32'(rf_reg_write), 32'(v && (first + idx) != 0));
      if (v) begin
        check("load_wreg", 32'(rf_write_reg), 32'(first + idx));
        check("load_wdata", rf_write_data, load_words[idx]);
        if (first + idx != 0) model_rf[first + idx] = load_words[idx];
        exp_ck ^= load_words[idx];
        idx++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (idx < n) begin
      total++; bad++;
      $error("FAIL load_timeout observed=%0d words expected=%0d", idx, n);
    end
    #1;
    check("load_done", 32'(done), 32'd1);
    check("load_idle", 32'(busy), 32'd0);
    check("load_in_ready_off", 32'(in_ready), 32'd0);
    check("load_checksum", checksum, exp_ck);
    check_rf();
    @(negedge clk);
    check("load_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int f, l;
    reset = 1'b1; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_first = '0; cmd_last = '0;
    out_ready = 1'b0; in_valid = 1'b0; in_data = '0; pre_we = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_rd_reg", 32'(rf_read_reg), 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 32; i++) preload(i, $urandom);
    for (int i = 0; i < 4; i++) preload(i, 32'(10 + i));

    do_dump(0, 3, 0);
    do_dump(5, 5, 2);

    load_words.delete();
    load_words.push_back(32'hA); load_words.push_back(32'hB); load_words.push_back(32'hC);
    do_load(0, 2, 1'b0);

    fill_random(2);
    do_load(30, 31, 1'b1);
    check("no_wrap_ptr", 32'(rf_read_reg), 32'd31);
    do_dump(28, 31, 1);

    // Inverted range is rejected.
    send_cmd(1'b0, 7, 3);
    check("err_done", 32'(done), 32'd1);
    check("err_err", 32'(err), 32'd1);
    check("err_idle", 32'(busy), 32'd0);
    check("err_no_valid", 32'(out_valid), 32'd0);
    check("err_no_we", 32'(rf_reg_write), 32'd0);
    check("err_checksum", checksum, 32'd0);
    @(negedge clk);
    check("err_done_pulse", 32'(done), 32'd0);
    check("err_err_pulse", 32'(err), 32'd0);

    // Load words offered while idle must be ignored.
    in_valid = 1'b1; in_data = $urandom; #1;
    check("idle_in_ready", 32'(in_ready), 32'd0);
    check("idle_no_we", 32'(rf_reg_write), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check_rf();

    // Reset in the middle of a load.
    fill_random(6);
    send_cmd(1'b1, 4, 9);
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = load_words[k]; model_rf[4 + k] = load_words[k];
      @(negedge clk);
    end
    reset = 1'b1; in_valid = 1'b1; in_data = $urandom; #1;
    check("rst_load_no_we", 32'(rf_reg_write), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; #1;
    check("rstl_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rstl_busy", 32'(busy), 32'd0);
    check("rstl_in_ready", 32'(in_ready), 32'd0);
    check("rstl_rd_reg", 32'(rf_read_reg), 32'd0);
    check("rstl_checksum", checksum, 32'd0);
    check("rstl_done", 32'(done), 32'd0);
    check("rstl_out_data", out_data, 32'd0);
    check("rstl_out_addr", 32'(out_addr), 32'd0);
    check("rstl_we", 32'(rf_reg_write), 32'd0);
    check_rf();
    do_dump(4, 6, 0);

    // Reset in the middle of a dump drops the pending word without done.
    send_cmd(1'b0, 10, 12);
    out_ready = 1'b0;
    @(negedge clk);
    check("rstd_pending", 32'(out_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstd_valid", 32'(out_valid), 32'd0);
    check("rstd_done", 32'(done), 32'd0);
    @(negedge clk);
    check("rstd_done_after", 32'(done), 32'd0);
    check("rstd_idle", 32'(busy), 32'd0);

    for (int t = 0; t < 14; t++) begin
      f = int'($urandom_range(0, 31));
      l = int'($urandom_range(31, f));
      if ($urandom_range(0, 1) == 1) begin
        fill_random(l - f + 1);
        do_load(f, l, 1'($urandom_range(0, 1)));
      end else begin
        do_dump(f, l, int'($urandom_range(0, 2)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
